// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared encodings and helpers for the load/store unit
package lsu_pkg;

  // Request size encodings; 2'b11 is treated as a word everywhere
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Largest supported memory read latency, also sizes the latency counter
  localparam int MEM_LAT_MAX = 15;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } lsu_state_e;

  function automatic logic size_is_word(input logic [1:0] size);
    return (size == SZ_WORD) || (size == 2'b11);
  endfunction

  // Half needs addr[0]=0, word needs addr[1:0]=0; bytes are always aligned
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
    if (size_is_word(size)) return lane != 2'b00;
    if (size == SZ_HALF)    return lane[0];
    return 1'b0;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - sub-word load lane extract/extend and store lane merge
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        sign_i,
  input  logic [1:0]  lane_i,
  input  logic [31:0] word_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_data_o,
  output logic [31:0] merged_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed lane out of the memory word and extend it
  always_comb begin
    byte_sel    = 8'h00;
    half_sel    = lane_i[1] ? word_i[31:16] : word_i[15:0];
    load_data_o = word_i;
    case (lane_i)
      2'd0:    byte_sel = word_i[7:0];
      2'd1:    byte_sel = word_i[15:8];
      2'd2:    byte_sel = word_i[23:16];
      default: byte_sel = word_i[31:24];
    endcase
    case (size_i)
      SZ_BYTE: load_data_o = {{24{sign_i & byte_sel[7]}}, byte_sel};
      SZ_HALF: load_data_o = {{16{sign_i & half_sel[15]}}, half_sel};
      default: load_data_o = word_i;
    endcase
  end

  // Replace only the addressed lane; the memory has no byte enables
  always_comb begin
    merged_o = word_i;
    case (size_i)
      SZ_BYTE: begin
        case (lane_i)
          2'd0:    merged_o[7:0]   = wdata_i[7:0];
          2'd1:    merged_o[15:8]  = wdata_i[7:0];
          2'd2:    merged_o[23:16] = wdata_i[7:0];
          default: merged_o[31:24] = wdata_i[7:0];
        endcase
      end
      SZ_HALF: begin
        if (lane_i[1]) merged_o[31:16] = wdata_i[15:0];
        else           merged_o[15:0]  = wdata_i[15:0];
      end
      default: merged_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - data-memory initiator with sub-word RMW; optional MISALIGN_TRAP_EN
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_read_data
);

  localparam int CNT_W = $clog2(MEM_LAT_MAX + 1);
  localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(MEM_LAT - 1);

  lsu_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic        write_q;
  logic [1:0]  size_q;
  logic        sign_q;
  logic [1:0]  lane_q;
  logic [31:0] mem_address_q;
  logic [31:0] mem_write_data_q;
  logic [31:0] resp_rdata_q;
  logic        resp_err_q;

  logic        accept;
  logic        trap;
  logic        read_last;
  logic [31:0] load_data;
  logic [31:0] merged;

  assign accept    = req_valid && (state_q == ST_IDLE);
  assign read_last = (state_q == ST_READ) && (cnt_q == LAT_LAST);

`ifdef MISALIGN_TRAP_EN
  assign trap = is_misaligned(req_size, req_addr[1:0]);
`else
  assign trap = 1'b0;
`endif

  // Store data sits in mem_write_data_q from acceptance, so it feeds the merge directly
  lsu_align u_align (
    .size_i      (size_q),
    .sign_i      (sign_q),
    .lane_i      (lane_q),
    .word_i      (mem_read_data),
    .wdata_i     (mem_write_data_q),
    .load_data_o (load_data),
    .merged_o    (merged)
  );

  // Next state, latency counter and state-decoded strobes
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_ready  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    resp_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        cnt_d     = '0;
        if (req_valid) begin
          if (trap)                                      state_d = ST_DONE;
          else if (req_write && size_is_word(req_size))  state_d = ST_WRITE;
          else                                           state_d = ST_READ;
        end
      end
      ST_READ: begin
        mem_read = 1'b1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAT_LAST) state_d = write_q ? ST_WRITE : ST_DONE;
      end
      ST_WRITE: begin
        mem_write = 1'b1;
        state_d   = ST_DONE;
      end
      ST_DONE: begin
        resp_valid = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Latch the request on acceptance and capture read data on the last READ cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_q          <= 1'b0;
      size_q           <= SZ_BYTE;
      sign_q           <= 1'b0;
      lane_q           <= 2'b00;
      mem_address_q    <= '0;
      mem_write_data_q <= '0;
      resp_rdata_q     <= '0;
      resp_err_q       <= 1'b0;
    end else begin
      if (accept) begin
        write_q       <= req_write;
        size_q        <= req_size;
        sign_q        <= req_signed;
        lane_q        <= req_addr[1:0];
        mem_address_q <= {2'b00, req_addr[31:2]};
        resp_rdata_q  <= '0;
        resp_err_q    <= trap;
        if (req_write) mem_write_data_q <= req_wdata;
      end
      if (read_last) begin
        if (write_q) mem_write_data_q <= merged;
        else         resp_rdata_q     <= load_data;
      end
    end
  end

  assign mem_address    = mem_address_q;
  assign mem_write_data = mem_write_data_q;
  assign resp_rdata     = resp_rdata_q;
  assign resp_err       = resp_err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - self-checking bench for load_store_unit
module tb_load_store_unit;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_read_data;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_read(mem_read), .mem_write(mem_write), .mem_read_data(mem_read_data)
  );

  // Data memory model plus activity monitors
  logic [31:0] mem [0:63];
  logic        pre_en = 1'b0;
  logic [5:0]  pre_idx = '0;
  logic [31:0] pre_dat = '0;
  int wr_cnt = 0, rd_cyc = 0, both_cnt = 0, cyc = 0, n_acc = 0, n_resp = 0;
  int acc_cyc [0:7];
  int resp_cyc [0:7];
  logic [31:0] resp_dat [0:7];

  assign mem_read_data = mem[mem_address[5:0]];

  always @(posedge clk) begin
    if (pre_en) mem[pre_idx] <= pre_dat;
    if (mem_write) begin
      mem[mem_address[5:0]] <= mem_write_data;
      wr_cnt <= wr_cnt + 1;
    end
    if (mem_read) rd_cyc <= rd_cyc + 1;
    if (mem_read && mem_write) both_cnt <= both_cnt + 1;
    if (req_valid && req_ready) begin
      acc_cyc[n_acc % 8] <= cyc;
      n_acc <= n_acc + 1;
    end
    cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (resp_valid) begin
      resp_cyc[n_resp % 8] <= cyc;
      resp_dat[n_resp % 8] <= resp_rdata;
      n_resp <= n_resp + 1;
    end
  end

  // Reference model: memory shadow and lane arithmetic
  logic [31:0] sh_mem [0:63];

  function automatic logic ref_trap(input logic [1:0] sz, input logic [1:0] a);
`ifdef MISALIGN_TRAP_EN
    if (sz == 2'd1) return a[0];
    if (sz >= 2'd2) return a != 2'd0;
    return 1'b0;
`else
    return 1'b0 & sz[0] & a[0];
`endif
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] sz,
                                           input logic sg, input logic [1:0] a);
    logic [31:0] v;
    if (sz == 2'd0) begin
      v = (w >> (8 * int'(a))) & 32'hFF;
      if (sg && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      v = (w >> (16 * int'(a[1]))) & 32'hFFFF;
      if (sg && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic logic [31:0] ref_store(input logic [31:0] old, input logic [1:0] sz,
                                            input logic [1:0] a, input logic [31:0] wd);
    logic [31:0] mask;
    if (sz == 2'd0) begin
      mask = 32'hFF << (8 * int'(a));
      return (old & ~mask) | ((wd & 32'hFF) << (8 * int'(a)));
    end else if (sz == 2'd1) begin
      mask = 32'hFFFF << (16 * int'(a[1]));
      return (old & ~mask) | ((wd & 32'hFFFF) << (16 * int'(a[1])));
    end
    return wd;
  endfunction

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=0x%h required=0x%h", nm, act, exp);
    end
  endtask

  task automatic preload(input int idx, input logic [31:0] d);
    @(negedge clk);
    pre_en  = 1'b1;
    pre_idx = idx[5:0];
    pre_dat = d;
    @(posedge clk);
    #1 pre_en = 1'b0;
    sh_mem[idx] = d;
  endtask

  task automatic do_req(input logic wr, input logic [1:0] sz, input logic sg,
                        input logic [31:0] addr, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int lat,
                        output int nwr, output int nrd, output int abad);
    int w0, r0, n;
    @(negedge clk);
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) chk("ready_timeout", {31'b0, req_ready}, 32'd1);
    req_write = wr; req_size = sz; req_signed = sg; req_addr = addr; req_wdata = wd;
    req_valid = 1'b1;
    w0 = wr_cnt; r0 = rd_cyc; abad = 0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    while (lat < 60) begin
      @(negedge clk);
      lat++;
      if ((mem_read || mem_write) && mem_address !== {2'b00, addr[31:2]}) abad++;
      if (resp_valid) break;
    end
    rd  = resp_rdata;
    er  = resp_err;
    nwr = wr_cnt - w0;
    nrd = rd_cyc - r0;
  endtask

  typedef struct {
    logic        wr;
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] pre;
    logic [31:0] exp_rd;
    logic [31:0] exp_mem;
    logic        exp_err;
    int          exp_lat;
    int          exp_wr;
    int          exp_rdc;
  } vec_t;

  vec_t tbl [0:11];

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd, exp_rd, exp_mem, v [0:2];
    logic        er, tr, wr, sg;
    logic [1:0]  sz;
    logic [31:0] addr, wd;
    int lat, nwr, nrd, abad, idx, w0, r0, base_a, base_r, guard, k, exp_lat;
    logic [31:0] b2b_addr [0:2];
    logic [1:0]  b2b_sz [0:2];
    logic        b2b_sg [0:2];

    //         wr    sz     sg    addr    wdata          preload        exp rdata      exp mem        err  lat     wr rdc
    tbl[0]  = '{1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 32'h00000000, 32'h00000000, 32'hDEADBEEF, 1'b0, 2,       1, 0};
    tbl[1]  = '{1'b0, 2'd2, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, LAT + 1, 0, LAT};
    tbl[2]  = '{1'b0, 2'd0, 1'b1, 32'h13, 32'h0,        32'h11223344, 32'h00000011, 32'h11223344, 1'b0, LAT + 1, 0, LAT};
    tbl[3]  = '{1'b0, 2'd0, 1'b1, 32'h10, 32'h0,        32'h11223380, 32'hFFFFFF80, 32'h11223380, 1'b0, LAT + 1, 0, LAT};
    tbl[4]  = '{1'b0, 2'd0, 1'b0, 32'h10, 32'h0,        32'h11223380, 32'h00000080, 32'h11223380, 1'b0, LAT + 1, 0, LAT};
    tbl[5]  = '{1'b1, 2'd0, 1'b0, 32'h11, 32'h0000005A, 32'hAABBCCDD, 32'h00000000, 32'hAABB5ADD, 1'b0, LAT + 2, 1, LAT};
    tbl[6]  = '{1'b1, 2'd1, 1'b0, 32'h12, 32'h00001234, 32'hAABB5ADD, 32'h00000000, 32'h12345ADD, 1'b0, LAT + 2, 1, LAT};
`ifdef MISALIGN_TRAP_EN
    tbl[7]  = '{1'b0, 2'd2, 1'b0, 32'h11, 32'h0,        32'h11223344, 32'h00000000, 32'h11223344, 1'b1, 1,       0, 0};
`else
    tbl[7]  = '{1'b0, 2'd2, 1'b0, 32'h11, 32'h0,        32'h11223344, 32'h11223344, 32'h11223344, 1'b0, LAT + 1, 0, LAT};
`endif
    tbl[8]  = '{1'b0, 2'd1, 1'b1, 32'h12, 32'h0,        32'h80017FFF, 32'hFFFF8001, 32'h80017FFF, 1'b0, LAT + 1, 0, LAT};
    tbl[9]  = '{1'b0, 2'd1, 1'b0, 32'h10, 32'h0,        32'h80017FFF, 32'h00007FFF, 32'h80017FFF, 1'b0, LAT + 1, 0, LAT};
    tbl[10] = '{1'b0, 2'd3, 1'b1, 32'h14, 32'h0,        32'hCAFEF00D, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0, LAT + 1, 0, LAT};
    tbl[11] = '{1'b1, 2'd0, 1'b0, 32'h13, 32'hFFFFFF77, 32'h00000000, 32'h00000000, 32'h77000000, 1'b0, LAT + 2, 1, LAT};

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_req_ready",  {31'b0, req_ready},  32'd1);
    chk("rst_mem_read",   {31'b0, mem_read},   32'd0);
    chk("rst_mem_write",  {31'b0, mem_write},  32'd0);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_resp_err",   {31'b0, resp_err},   32'd0);
    chk("rst_resp_rdata", resp_rdata,          32'd0);
    chk("rst_mem_addr",   mem_address,         32'd0);
    chk("rst_mem_wdata",  mem_write_data,      32'd0);

    for (int i = 0; i < 64; i++) preload(i, $urandom);

    // Directed table
    for (int i = 0; i < 12; i++) begin
      idx = int'(tbl[i].addr[7:2]);
      preload(idx, tbl[i].pre);
      do_req(tbl[i].wr, tbl[i].sz, tbl[i].sg, tbl[i].addr, tbl[i].wd, rd, er, lat, nwr, nrd, abad);
      chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rd);
      chk($sformatf("tbl%0d_err", i), {31'b0, er}, {31'b0, tbl[i].exp_err});
      chk($sformatf("tbl%0d_latency", i), lat, tbl[i].exp_lat);
      chk($sformatf("tbl%0d_writes", i), nwr, tbl[i].exp_wr);
      chk($sformatf("tbl%0d_read_cycles", i), nrd, tbl[i].exp_rdc);
      chk($sformatf("tbl%0d_addr_stable", i), abad, 0);
      chk($sformatf("tbl%0d_mem", i), mem[idx], tbl[i].exp_mem);
      sh_mem[idx] = tbl[i].exp_mem;
    end

    // Randomized traffic against the reference model
    for (int i = 0; i < 200; i++) begin
      addr = 32'($urandom_range(0, 255));
      sz   = 2'($urandom_range(0, 3));
      wr   = 1'($urandom_range(0, 1));
      sg   = 1'($urandom_range(0, 1));
      wd   = $urandom;
      idx  = int'(addr[7:2]);
      tr   = ref_trap(sz, addr[1:0]);
      exp_mem = sh_mem[idx];
      exp_rd  = 32'd0;
      if (tr)           exp_lat = 1;
      else if (wr)      exp_lat = (sz >= 2'd2) ? 2 : LAT + 2;
      else              exp_lat = LAT + 1;
      if (!tr && wr)  exp_mem = ref_store(sh_mem[idx], sz, addr[1:0], wd);
      if (!tr && !wr) exp_rd  = ref_load(sh_mem[idx], sz, sg, addr[1:0]);
      do_req(wr, sz, sg, addr, wd, rd, er, lat, nwr, nrd, abad);
      chk($sformatf("rnd%0d_rdata", i), rd, exp_rd);
      chk($sformatf("rnd%0d_err", i), {31'b0, er}, {31'b0, tr});
      chk($sformatf("rnd%0d_latency", i), lat, exp_lat);
      chk($sformatf("rnd%0d_writes", i), nwr, (!tr && wr) ? 1 : 0);
      chk($sformatf("rnd%0d_mem", i), mem[idx], exp_mem);
      sh_mem[idx] = exp_mem;
    end

    // Reset in the READ phase of a sub-word store
    preload(4, 32'hAABBCCDD);
    w0 = wr_cnt;
    r0 = n_resp;
    @(negedge clk);
    req_write = 1'b1; req_size = 2'd0; req_signed = 1'b0; req_addr = 32'h11; req_wdata = 32'h5A;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("abort_in_read", {31'b0, mem_read}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_mem_read",  {31'b0, mem_read},  32'd0);
    chk("abort_mem_write", {31'b0, mem_write}, 32'd0);
    chk("abort_req_ready", {31'b0, req_ready}, 32'd1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("abort_no_resp",  n_resp - r0, 0);
    chk("abort_no_write", wr_cnt - w0, 0);
    chk("abort_mem_kept", mem[4], 32'hAABBCCDD);
    sh_mem[4] = 32'hAABBCCDD;

    // Back-to-back loads with req_valid held high
    v[0] = 32'h8899AABB; v[1] = 32'h01F2E3D4; v[2] = 32'hC0DE8765;
    for (int i = 0; i < 3; i++) preload(8 + i, v[i]);
    b2b_addr[0] = 32'h20; b2b_sz[0] = 2'd2; b2b_sg[0] = 1'b0;
    b2b_addr[1] = 32'h25; b2b_sz[1] = 2'd0; b2b_sg[1] = 1'b1;
    b2b_addr[2] = 32'h2A; b2b_sz[2] = 2'd1; b2b_sg[2] = 1'b0;
    base_a = n_acc;
    base_r = n_resp;
    @(negedge clk);
    req_write = 1'b0; req_size = b2b_sz[0]; req_signed = b2b_sg[0]; req_addr = b2b_addr[0];
    req_valid = 1'b1;
    guard = 0;
    while (n_acc - base_a < 3 && guard < 100) begin
      @(negedge clk);
      guard++;
      k = n_acc - base_a;
      if (k < 3) begin
        req_size = b2b_sz[k]; req_signed = b2b_sg[k]; req_addr = b2b_addr[k];
      end
    end
    req_valid = 1'b0;
    guard = 0;
    while (n_resp - base_r < 3 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    repeat (4) @(negedge clk);
    chk("b2b_accepts", n_acc - base_a, 3);
    chk("b2b_resps", n_resp - base_r, 3);
    for (int i = 0; i < 3; i++) begin
      exp_rd = ref_load(v[i], b2b_sz[i], b2b_sg[i], b2b_addr[i][1:0]);
      chk($sformatf("b2b%0d_rdata", i), resp_dat[(base_r + i) % 8], exp_rd);
      chk($sformatf("b2b%0d_latency", i),
          resp_cyc[(base_r + i) % 8] - acc_cyc[(base_a + i) % 8], LAT + 1);
      if (i > 0)
        chk($sformatf("b2b%0d_idle_gap", i),
            acc_cyc[(base_a + i) % 8] - resp_cyc[(base_r + i - 1) % 8], 1);
    end

    chk("strobes_exclusive", both_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
